// File: rtl/kds_feeder.sv
// Load/rotate sequencer feeding the kernel data shifter: steers 3-word beats into lanes, then recirculates.
// Optional LOAD stall counter enabled by defining KDS_FEEDER_PERF_CNT_EN.
module kds_feeder #(
  parameter int unsigned IO_DATA_WIDTH = 16,
  parameter int unsigned NB_LANES      = 12,
  parameter int unsigned LANE_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     start,
  input  logic [7:0]               cfg_rotate_cycles,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IO_DATA_WIDTH-1:0] in_data_0,
  input  logic [IO_DATA_WIDTH-1:0] in_data_1,
  input  logic [IO_DATA_WIDTH-1:0] in_data_2,
  output logic [IO_DATA_WIDTH-1:0] v_1,
  output logic [IO_DATA_WIDTH-1:0] v_2,
  output logic [IO_DATA_WIDTH-1:0] v_3,
  output logic [NB_LANES-1:0]      LE_select,
  output logic                     cycle_enable,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              stall_cycles
);

  localparam int unsigned BEAT_W = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int unsigned LANE_W = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ROTATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [7:0]               rot_q, rot_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [IO_DATA_WIDTH-1:0] v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [NB_LANES-1:0]      le_q, le_d;
  logic                     ce_q, ce_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  // Next-state and registered-output decode; outputs reflect the state of the previous cycle.
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    le_d    = '0;
    ce_d    = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rot_d   = cfg_rotate_cycles;
          lane_d  = '0;
          beat_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          v1_d = in_data_0;
          v2_d = in_data_1;
          v3_d = in_data_2;
          le_d = NB_LANES'(1) << lane_q;
          if (beat_q == BEAT_W'(LANE_DEPTH - 1)) begin
            beat_d = '0;
            if (lane_q == LANE_W'(NB_LANES - 1)) begin
              lane_d  = '0;
              state_d = (rot_q != 8'd0) ? S_ROTATE : S_DONE;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_ROTATE: begin
        ce_d  = 1'b0;
        rot_d = rot_q - 8'd1;
        if (rot_q == 8'd1) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      rot_q   <= '0;
      lane_q  <= '0;
      beat_q  <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      le_q    <= '0;
      ce_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      le_q    <= le_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Ready depends on state only so upstream never sees a valid->ready loop.
  assign in_ready     = (state_q == S_LOAD);
  assign v_1          = v1_q;
  assign v_2          = v2_q;
  assign v_3          = v3_q;
  assign LE_select    = le_q;
  assign cycle_enable = ce_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef KDS_FEEDER_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of LOAD cycles starved by upstream.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_LOAD && !in_valid && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_kds_feeder.sv
// Directed bench for kds_feeder: sequence-level reference model checked every cycle plus literal pins.
module tb_kds_feeder;

`ifdef KDS_FEEDER_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif
  localparam int NBEATS = 96;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_ROT = 2, PH_DONE = 3;

  logic        clk, rst_in, start, in_valid, in_ready;
  logic [7:0]  cfg;
  logic [15:0] in_data_0, in_data_1, in_data_2, v_1, v_2, v_3;
  logic [11:0] LE_select;
  logic        cycle_enable, busy, done;
  logic [31:0] stall_cycles;

  kds_feeder dut (
    .clk(clk), .rst_in(rst_in), .start(start), .cfg_rotate_cycles(cfg),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2),
    .v_1(v_1), .v_2(v_2), .v_3(v_3), .LE_select(LE_select),
    .cycle_enable(cycle_enable), .busy(busy), .done(done), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_err = 0;
  int cyc = 0, s_cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model in sequence terms: phase, beats accepted so far, rotate cycles left.
  int          m_phase, m_nacc, m_rot;
  logic [15:0] e_v1, e_v2, e_v3;
  logic [11:0] e_le;
  bit          e_ce, e_done, e_busy;
  int unsigned e_stall;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_in) begin
      m_phase = PH_IDLE; m_nacc = 0; m_rot = 0;
      e_v1 = '0; e_v2 = '0; e_v3 = '0; e_le = '0;
      e_ce = 1'b1; e_done = 1'b0; e_busy = 1'b0; e_stall = 0;
    end else begin
      e_le   = '0;
      e_ce   = (m_phase != PH_ROT);
      e_done = (m_phase == PH_DONE);
      case (m_phase)
        PH_IDLE: if (start) begin
          m_rot = int'(cfg); m_nacc = 0; e_stall = 0; m_phase = PH_LOAD;
        end
        PH_LOAD: if (in_valid) begin
          e_v1 = in_data_0; e_v2 = in_data_1; e_v3 = in_data_2;
          e_le = 12'(1) << (m_nacc / 8);
          m_nacc++;
          if (m_nacc == NBEATS) m_phase = (m_rot != 0) ? PH_ROT : PH_DONE;
        end else if (PERF != 0) begin
          e_stall++;
        end
        PH_ROT: begin
          m_rot--;
          if (m_rot == 0) m_phase = PH_DONE;
        end
        default: m_phase = PH_IDLE;
      endcase
      e_busy = (m_phase != PH_IDLE);
    end
  end

  // Per-sequence statistics and snapshots gathered by the compare process.
  int n_ce0, n_le, n_done, done_cyc;
  logic [31:0] s2_v1, s2_v2, s2_le, s19_v1, s19_v3, s19_le, s97_v1, s97_le, s97_ce, s98_ce, s98_le;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == PH_LOAD));
      check("v_1", 32'(v_1), 32'(e_v1));
      check("v_2", 32'(v_2), 32'(e_v2));
      check("v_3", 32'(v_3), 32'(e_v3));
      check("LE_select", 32'(LE_select), 32'(e_le));
      check("cycle_enable", 32'(cycle_enable), 32'(e_ce));
      check("done", 32'(done), 32'(e_done));
      check("busy", 32'(busy), 32'(e_busy));
      check("stall_cycles", stall_cycles, 32'(e_stall));
      if (cycle_enable === 1'b0) n_ce0++;
      if (LE_select !== 12'd0) n_le++;
      if (done === 1'b1) begin n_done++; done_cyc = cyc; end
      case (cyc - s_cyc)
        2:  begin s2_v1 = 32'(v_1); s2_v2 = 32'(v_2); s2_le = 32'(LE_select); end
        19: begin s19_v1 = 32'(v_1); s19_v3 = 32'(v_3); s19_le = 32'(LE_select); end
        97: begin s97_v1 = 32'(v_1); s97_le = 32'(LE_select); s97_ce = 32'(cycle_enable); end
        98: begin s98_ce = 32'(cycle_enable); s98_le = 32'(LE_select); end
        default: ;
      endcase
    end
  end

  task automatic do_start(input logic [7:0] r);
    start = 1'b1; cfg = r; s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present beats {3k,3k+1,3k+2} until stop_at are accepted; optional gaps and a start poke at beat poke_at.
  task automatic feed(input bit gaps, input int stop_at, input int poke_at);
    int k, guard;
    bit ph, vld, acc;
    k = 0; guard = 0; ph = 1'b0;
    while (k < stop_at && guard < 2000) begin
      vld = gaps ? ph : 1'b1;
      ph = ~ph;
      guard++;
      in_valid = vld;
      if (vld) begin
        in_data_0 = 16'(3 * k); in_data_1 = 16'(3 * k + 1); in_data_2 = 16'(3 * k + 2);
      end else begin
        in_data_0 = 16'($urandom); in_data_1 = 16'($urandom); in_data_2 = 16'($urandom);
      end
      start = (k == poke_at);
      acc = vld && (in_ready === 1'b1);
      @(negedge clk);
      if (acc) k++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (guard >= 2000) check("feed_timeout", 32'(k), 32'(stop_at));
  endtask

  task automatic run_seq(input logic [7:0] r, input bit gaps, input int poke, input logic [7:0] r_late,
                         output int dc);
    int g;
    n_ce0 = 0; n_le = 0; n_done = 0; done_cyc = -1;
    do_start(r);
    cfg = r_late;
    feed(gaps, NBEATS, poke);
    g = 0;
    while (n_done == 0 && g < 300) begin
      start = (poke >= 0 && g == 1);
      @(negedge clk);
      g++;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("done_pulses", 32'(n_done), 32'd1);
    dc = done_cyc - s_cyc;
  endtask

  initial begin
    int dc;
    rst_in = 1'b1; start = 1'b0; cfg = 8'd0; in_valid = 1'b0;
    in_data_0 = '0; in_data_1 = '0; in_data_2 = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_le", 32'(LE_select), 32'd0);
    check("rst_ce", 32'(cycle_enable), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst_in = 1'b0;
    @(negedge clk);

    // Back-to-back load, rotate 4.
    run_seq(8'd4, 1'b0, -1, 8'd4, dc);
    check("a_done_cycle", 32'(dc), 32'd102);
    check("a_rot_cycles", 32'(n_ce0), 32'd4);
    check("a_le_cycles", 32'(n_le), 32'd96);
    check("a_b0_v2", s2_v2, 32'd1);
    check("a_b0_le", s2_le, 32'd1);
    check("a_b17_v1", s19_v1, 32'd51);
    check("a_b17_v3", s19_v3, 32'd53);
    check("a_b17_le", s19_le, 32'd4);
    check("a_b95_v1", s97_v1, 32'd285);
    check("a_b95_le", s97_le, 32'h800);
    check("a_b95_ce", s97_ce, 32'd1);
    check("a_rot_ce", s98_ce, 32'd0);
    check("a_rot_le", s98_le, 32'd0);
    check("a_stall", stall_cycles, 32'd0);

    // Upstream gaps every other cycle.
    run_seq(8'd4, 1'b1, -1, 8'd4, dc);
    check("b_done_cycle", 32'(dc), 32'd198);
    check("b_le_cycles", 32'(n_le), 32'd96);
    check("b_rot_cycles", 32'(n_ce0), 32'd4);
    check("b_stall", stall_cycles, (PERF != 0) ? 32'd96 : 32'd0);

    // Zero rotate length.
    run_seq(8'd0, 1'b0, -1, 8'd0, dc);
    check("c_done_cycle", 32'(dc), 32'd98);
    check("c_rot_cycles", 32'(n_ce0), 32'd0);
    check("c_stall_cleared", stall_cycles, 32'd0);

    // Start pulses during LOAD and ROTATE are ignored.
    run_seq(8'd4, 1'b0, 40, 8'd4, dc);
    check("d_done_cycle", 32'(dc), 32'd102);
    check("d_le_cycles", 32'(n_le), 32'd96);
    check("d_busy_after", 32'(busy), 32'd0);

    // Reset after 50 beats, then a fresh sequence.
    do_start(8'd3);
    feed(1'b0, 50, -1);
    rst_in = 1'b1;
    @(negedge clk);
    check("e_rst_v1", 32'(v_1), 32'd0);
    check("e_rst_le", 32'(LE_select), 32'd0);
    check("e_rst_busy", 32'(busy), 32'd0);
    check("e_rst_ready", 32'(in_ready), 32'd0);
    rst_in = 1'b0;
    @(negedge clk);
    run_seq(8'd3, 1'b0, -1, 8'd3, dc);
    check("e_done_cycle", 32'(dc), 32'd101);
    check("e_b0_v1", s2_v1, 32'd0);
    check("e_b0_v2", s2_v2, 32'd1);
    check("e_b0_le", s2_le, 32'd1);

    // Rotate length latched at start; later cfg change has no effect.
    run_seq(8'd2, 1'b0, -1, 8'd9, dc);
    check("f_rot_cycles", 32'(n_ce0), 32'd2);
    check("f_done_cycle", 32'(dc), 32'd100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kds_feeder.md
# kds_feeder

Sequencer directly upstream of the kernel data shifter (KDS). Accepts a valid/ready stream of 3-word kernel beats (one word per kernel row), steers each beat into one of 12 three-FIFO lanes by driving `v_1`/`v_2`/`v_3` and a one-hot `LE_select`, then runs a programmable rotate phase by driving `cycle_enable` low so the shifter recirculates. Reports completion with a one-cycle `done` pulse.

## Interface
- `IO_DATA_WIDTH`, 16, width of each data word.
- `NB_LANES`, 12, number of shifter lanes; `LE_select` width.
- `LANE_DEPTH`, 8, beats loaded per lane (matches the 8-deep lane FIFOs).
- `clk` in 1: single clock, all logic on rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `start` in 1: begin one load+rotate sequence; honoured only in IDLE.
- `cfg_rotate_cycles` in 8: rotate length, sampled on accepted `start`.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: feeder accepts a beat this cycle.
- `in_data_0`, `in_data_1`, `in_data_2` in IO_DATA_WIDTH each: beat words.
- `v_1`, `v_2`, `v_3` out IO_DATA_WIDTH each: words to shifter.
- `LE_select` out NB_LANES: one-hot lane write select.
- `cycle_enable` out 1: 1 = shifter holds, 0 = shifter recirculates.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at sequence end.
- `stall_cycles` out 32: LOAD-state cycles with `in_valid` low (see Configuration).

## Operation
- States: IDLE, LOAD, ROTATE, DONE.
- IDLE: `in_ready`=0, `busy`=0. `start`=1 → latch `cfg_rotate_cycles` into `rot_cnt`, clear `lane_cnt` and `beat_cnt`, go LOAD.
- LOAD: `in_ready`=1. Accept = `in_valid & in_ready`.
  - On accept, next cycle: `v_1/v_2/v_3` = `in_data_0/1/2`, `LE_select` = one-hot(`lane_cnt`), `cycle_enable`=1.
  - No accept, next cycle: `LE_select`=0, `cycle_enable`=1, `v_*` hold last value.
  - `beat_cnt` (width clog2(LANE_DEPTH)) increments per accept; at LANE_DEPTH-1 wraps to 0 and `lane_cnt` increments.
  - Accept with `beat_cnt`=LANE_DEPTH-1 and `lane_cnt`=NB_LANES-1 → ROTATE if latched `rot_cnt`≠0, else DONE. Exactly NB_LANES·LANE_DEPTH beats accepted per sequence.
- ROTATE: `in_ready`=0, registered outputs `LE_select`=0, `cycle_enable`=0 for exactly `rot_cnt` cycles; `rot_cnt` decrements each cycle; at 1 → DONE.
- DONE: `done`=1 for one cycle, `cycle_enable` returns to 1, → IDLE.
- `start` outside IDLE ignored, no queuing.
- `in_data_*` ignored when not accepted.

## Timing
- Reset values: `v_*`=0, `LE_select`=0, `cycle_enable`=1, `in_ready`=0, `busy`=0, `done`=0, `stall_cycles`=0, state IDLE, all counters 0.
- `rst_in` mid-sequence: next edge returns to IDLE with reset values; partially loaded beats discarded.
- `in_ready` combinational from state only (no dependence on `in_valid`).
- Latency: accepted beat appears on `v_*`/`LE_select` one cycle after acceptance; outputs registered.
- `start` to first possible accept: 1 cycle (LOAD entered next edge).
- Full sequence with no stalls: 1 + NB_LANES·LANE_DEPTH + `rot_cnt` + 1 cycles from `start` to `done`.
- `busy` high from cycle after accepted `start` through DONE cycle inclusive.

## Configuration
- `KDS_FEEDER_PERF_CNT_EN` defined: `stall_cycles` increments (saturating at 2^32-1) every LOAD cycle with `in_valid`=0; cleared on accepted `start` and on reset.
- Undefined: counter logic not compiled; `stall_cycles` tied to 0.

## Test plan
- Reset, then `start` with `cfg_rotate_cycles`=4, 96 back-to-back beats with words {3k, 3k+1, 3k+2} → beat k on `v_*` one cycle after accept, `LE_select`=1<<(k/8), then 4 cycles `cycle_enable`=0/`LE_select`=0, `done` at cycle 102.
- Same load with `in_valid` dropped every other cycle → 96 stall cycles inserted with `LE_select`=0, `cycle_enable`=1; `stall_cycles`=96 (macro defined) or 0 (undefined).
- `cfg_rotate_cycles`=0 → no ROTATE cycle; DONE immediately after final beat, `cycle_enable` never 0.
- `start` pulsed during LOAD and ROTATE → ignored; exactly one `done`, counters unaffected.
- `rst_in` asserted after 50 beats → next cycle IDLE, all outputs at reset values; new `start` reloads from lane 0 beat 0.
- `cfg_rotate_cycles` changed to 9 after `start` accepted with value 2 → rotate lasts 2 cycles.
